// File: rtl/fluxo_dados_pkg.sv
// rtl/fluxo_dados_pkg.sv - shared types and constants for the game datapath
package fluxo_dados_pkg;

  localparam logic PAPEL_ALDEAO = 1'b0;
  localparam logic PAPEL_LOBO   = 1'b1;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] SEED_ZERO_DEF = 16'hACE1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LIMPA   = 2'd1,
    SORTEIA = 2'd2,
    PRONTO  = 2'd3
  } estado_t;

  function automatic logic [15:0] lfsr_passo(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with synchronous load and step enable
module lfsr16
  import fluxo_dados_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)    q_d = seed;
    else if (en) q_d = lfsr_passo(q_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fluxo_dados_jogo.sv
// rtl/fluxo_dados_jogo.sv - game datapath: seed counter, role draw, player counter
// Optional PASSA_SYNC_EN: synchronize and edge-detect the pass button.
module fluxo_dados_jogo
  import fluxo_dados_pkg::*;
#(
  parameter int          N_JOGADORES = 8,
  parameter int          N_LOBOS     = 2,
  parameter logic [15:0] SEED_ZERO   = SEED_ZERO_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             rst_global,
  input  logic                             zera_CS,
  input  logic                             e_seed_reg,
  input  logic                             zera_CJ,
  input  logic                             inc_jogador,
  input  logic                             passa_btn,
  output logic                             passa,
  output logic                             CJ_fim,
  output logic                             papeis_prontos,
  output logic [$clog2(N_JOGADORES+1)-1:0] jogador_atual,
  output logic                             papel_atual,
  output logic [N_JOGADORES-1:0]           db_papeis,
  output logic [15:0]                      db_seed
);

  localparam int JW    = $clog2(N_JOGADORES + 1);
  localparam int IDX_W = $clog2(N_JOGADORES);
  localparam int CW    = $clog2(N_LOBOS + 1);

  estado_t                 state_q;
  logic [N_JOGADORES-1:0]  papeis_q;
  logic [CW-1:0]           count_q;
  logic [15:0]             cs_q, cs_d;
  logic [15:0]             seed_q, seed_d;
  logic [JW-1:0]           cj_q, cj_d;
  logic [15:0]             lfsr_q;
  logic                    captura;
  logic [15:0]             seed_capt;
  logic [IDX_W-1:0]        idx;
  logic                    papel_d;

  // Seed only recaptured while no draw is in progress.
  assign captura   = e_seed_reg && !rst_global && (state_q == OCIOSO || state_q == PRONTO);
  assign seed_capt = (cs_q == 16'd0) ? SEED_ZERO : cs_q;
  assign idx       = lfsr_q[IDX_W-1:0];

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset & ~rst_global),
    .load  (captura),
    .en    (state_q == SORTEIA),
    .seed  (seed_capt),
    .q     (lfsr_q)
  );

  always_comb begin
    cs_d = zera_CS ? 16'd0 : cs_q + 16'd1;

    seed_d = seed_q;
    if (rst_global)   seed_d = 16'd0;
    else if (captura) seed_d = seed_capt;

    cj_d = cj_q;
    if (rst_global || zera_CJ)                            cj_d = '0;
    else if (inc_jogador && cj_q != JW'(N_JOGADORES))     cj_d = cj_q + 1'b1;

    papel_d = PAPEL_ALDEAO;
    for (int i = 0; i < N_JOGADORES; i++)
      if (cj_q == JW'(i + 1)) papel_d = papeis_q[i];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cs_q   <= '0;
      seed_q <= '0;
      cj_q   <= '0;
    end else begin
      cs_q   <= cs_d;
      seed_q <= seed_d;
      cj_q   <= cj_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || rst_global) begin
      state_q  <= OCIOSO;
      papeis_q <= '0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        OCIOSO:  if (e_seed_reg) state_q <= LIMPA;
        LIMPA: begin
          papeis_q <= '0;
          count_q  <= '0;
          state_q  <= SORTEIA;
        end
        SORTEIA: begin
          if (count_q == CW'(N_LOBOS)) begin
            state_q <= PRONTO;
          end else begin
            // Draws that land beyond the player range or on a werewolf are rejected.
            for (int i = 0; i < N_JOGADORES; i++) begin
              if (idx == IDX_W'(i) && !papeis_q[i]) begin
                papeis_q[i] <= PAPEL_LOBO;
                count_q     <= count_q + 1'b1;
              end
            end
          end
        end
        PRONTO:  if (e_seed_reg) state_q <= LIMPA;
        default: state_q <= OCIOSO;
      endcase
    end
  end

`ifdef PASSA_SYNC_EN
  logic [2:0] sync_q, sync_d;
  logic       passa_q, passa_d;

  always_comb begin
    sync_d  = {sync_q[1:0], passa_btn};
    passa_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      passa_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      passa_q <= passa_d;
    end
  end

  assign passa = passa_q;
`else
  assign passa = passa_btn;
`endif

  assign CJ_fim         = (cj_q == JW'(N_JOGADORES));
  assign papeis_prontos = (state_q == PRONTO);
  assign jogador_atual  = cj_q;
  assign papel_atual    = papel_d;
  assign db_papeis      = papeis_q;
  assign db_seed        = seed_q;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// tb/tb_fluxo_dados_jogo.sv - directed self-checking bench with draw scoreboard
module tb_fluxo_dados_jogo;

  logic        clock = 1'b0;
  logic        reset, rst_global, zera_CS, e_seed_reg, zera_CJ, inc_jogador, passa_btn;
  logic        passa, CJ_fim, papeis_prontos, papel_atual;
  logic [3:0]  jogador_atual;
  logic [7:0]  db_papeis;
  logic [15:0] db_seed;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] seed;
    logic [7:0]  papeis;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] papeis_ref;
  logic [3:0] jog_exp;
  int         pulses;

  fluxo_dados_jogo dut (
    .clock          (clock),
    .reset          (reset),
    .rst_global     (rst_global),
    .zera_CS        (zera_CS),
    .e_seed_reg     (e_seed_reg),
    .zera_CJ        (zera_CJ),
    .inc_jogador    (inc_jogador),
    .passa_btn      (passa_btn),
    .passa          (passa),
    .CJ_fim         (CJ_fim),
    .papeis_prontos (papeis_prontos),
    .jogador_atual  (jogador_atual),
    .papel_atual    (papel_atual),
    .db_papeis      (db_papeis),
    .db_seed        (db_seed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference draw: 8 players, 2 werewolves, Galois mask B400.
  function automatic logic [7:0] draw_model(input logic [15:0] s);
    logic [15:0] l = s;
    logic [7:0]  p = '0;
    int          c = 0;
    for (int k = 0; k < 1000 && c < 2; k++) begin
      if (!p[l[2:0]]) begin
        p[l[2:0]] = 1'b1;
        c++;
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    return p;
  endfunction

  task automatic check_draw(input string tag);
    int n = 0;
    while (!papeis_prontos && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_prontos"}, {31'd0, papeis_prontos}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_seed"}, {16'd0, db_seed}, {16'd0, e.seed});
      chk({tag, "_papeis"}, {24'd0, db_papeis}, {24'd0, e.papeis});
      chk({tag, "_popcount"}, $countones(db_papeis), 32'd2);
    end else begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0; rst_global = 1'b1; zera_CS = 1'b1; e_seed_reg = 1'b1;
    zera_CJ = 1'b0; inc_jogador = 1'b1; passa_btn = 1'b0;
    tick();
    tick();
    chk("rst_passa",   {31'd0, passa}, 32'd0);
    chk("rst_cj_fim",  {31'd0, CJ_fim}, 32'd0);
    chk("rst_prontos", {31'd0, papeis_prontos}, 32'd0);
    chk("rst_jogador", {28'd0, jogador_atual}, 32'd0);
    chk("rst_papel",   {31'd0, papel_atual}, 32'd0);
    chk("rst_papeis",  {24'd0, db_papeis}, 32'd0);
    chk("rst_seed",    {16'd0, db_seed}, 32'd0);

    reset = 1'b1; rst_global = 1'b0; zera_CS = 1'b0; e_seed_reg = 1'b0; inc_jogador = 1'b0;
    tick();

`ifdef PASSA_SYNC_EN
    pulses = 0;
    passa_btn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 10) passa_btn = 1'b0;
      tick();
      if (passa) pulses++;
    end
    chk("passa_one_pulse", pulses, 32'd1);
`else
    passa_btn = 1'b1;
    #1;
    chk("passa_track_hi", {31'd0, passa}, 32'd1);
    passa_btn = 1'b0;
    #1;
    chk("passa_track_lo", {31'd0, passa}, 32'd0);
`endif

    // Seed 100, drawn twice: same seed must reproduce the same roles.
    for (int r = 0; r < 2; r++) begin
      zera_CS = 1'b1;
      tick();
      zera_CS = 1'b0;
      repeat (100) tick();
      e_seed_reg = 1'b1;
      sb.push_back('{16'd100, draw_model(16'd100)});
      tick();
      e_seed_reg = 1'b0;
      chk("seed100_capture", {16'd0, db_seed}, 32'd100);
      chk("seed100_not_ready", {31'd0, papeis_prontos}, 32'd0);
      check_draw("draw100");
    end

    // Seed counter at zero captures the lock-up-safe constant.
    zera_CS = 1'b1;
    tick();
    e_seed_reg = 1'b1;
    sb.push_back('{16'hACE1, draw_model(16'hACE1)});
    tick();
    zera_CS = 1'b0; e_seed_reg = 1'b0;
    chk("seed_zero_capture", {16'd0, db_seed}, 32'h0000ACE1);
    check_draw("drawACE1");
    papeis_ref = draw_model(16'hACE1);

    zera_CJ = 1'b1;
    tick();
    zera_CJ = 1'b0;
    chk("cj_zero", {28'd0, jogador_atual}, 32'd0);
    chk("cj_zero_papel", {31'd0, papel_atual}, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      inc_jogador = 1'b1;
      tick();
      jog_exp = (k > 8) ? 4'd8 : 4'(k);
      chk($sformatf("cj_step%0d", k), {28'd0, jogador_atual}, {28'd0, jog_exp});
      chk($sformatf("cj_fim%0d", k), {31'd0, CJ_fim}, {31'd0, (jog_exp == 4'd8)});
      chk($sformatf("papel%0d", k), {31'd0, papel_atual}, {31'd0, papeis_ref[jog_exp-4'd1]});
    end
    zera_CJ = 1'b1;
    tick();
    zera_CJ = 1'b0; inc_jogador = 1'b0;
    chk("cj_zera_wins", {28'd0, jogador_atual}, 32'd0);

    // Abort a draw in SORTEIA; the seed counter keeps running through rst_global.
    zera_CS = 1'b1;
    tick();
    zera_CS = 1'b0;
    repeat (3) tick();
    e_seed_reg = 1'b1;
    tick();
    e_seed_reg = 1'b0;
    chk("abort_seed", {16'd0, db_seed}, 32'd3);
    tick();
    rst_global = 1'b1;
    tick();
    rst_global = 1'b0;
    chk("abort_papeis", {24'd0, db_papeis}, 32'd0);
    chk("abort_prontos", {31'd0, papeis_prontos}, 32'd0);
    chk("abort_seed_clr", {16'd0, db_seed}, 32'd0);
    repeat (4) tick();
    e_seed_reg = 1'b1;
    sb.push_back('{16'd10, draw_model(16'd10)});
    tick();
    chk("cs_kept_counting", {16'd0, db_seed}, 32'd10);
    tick();
    e_seed_reg = 1'b0;
    chk("seed_ignored_limpa", {16'd0, db_seed}, 32'd10);
    check_draw("draw10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
